rld1_dec: RTL and testbench



---
 rtl/rld1_dec.sv | 116 +++++++++++
 tb/tb_rld1_dec.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rld1_dec.sv
// Run-length decoder: expands {symbol, count, last} records into one {symbol, last} word per cycle.
// Optional statistics counters are built when RLD1_STATS_EN is defined.
module rld1_dec #(
    parameter int unsigned CNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CNT_W+1:0]   rld1__input_r,
    input  logic               rld1__input_r_vld,
    output logic               rld1__input_r_rdy,
    output logic [1:0]         rld1__output_s,
    output logic               rld1__output_s_vld,
    input  logic               rld1__output_s_rdy
`ifdef RLD1_STATS_EN
    ,
    output logic [15:0]        rld1__stat_words,
    output logic [7:0]         rld1__stat_zero
`endif
);

    localparam int unsigned REC_W = CNT_W + 2;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    state_t             busy_q;
    logic               sym_q;
    logic               last_q;
    logic [CNT_W-1:0]   rem_q;
    logic [1:0]         out_q;
    logic               out_vld_q;

    logic               rec_sym;
    logic [CNT_W-1:0]   rec_cnt;
    logic               rec_last;
    logic               rec_cnt_nz;
    logic               rem_one;
    logic               out_load;
    logic               emit;
    logic               accept;

    // Record field split.
    assign rec_sym    = rld1__input_r[REC_W-1];
    assign rec_cnt    = rld1__input_r[CNT_W:1];
    assign rec_last   = rld1__input_r[0];
    assign rec_cnt_nz = (rec_cnt != '0);

    assign rem_one  = (rem_q == CNT_W'(1));
    assign out_load = ~out_vld_q | rld1__output_s_rdy;
    assign emit     = (busy_q == EXPAND) & out_load;

    // Ready early on the final word so consecutive runs stream without a bubble.
    assign rld1__input_r_rdy = reset & ((busy_q == IDLE) | (rem_one & out_load));
    assign accept            = rld1__input_r_vld & rld1__input_r_rdy;

    assign rld1__output_s     = out_q;
    assign rld1__output_s_vld = out_vld_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q    <= IDLE;
            sym_q     <= 1'b0;
            last_q    <= 1'b0;
            rem_q     <= '0;
            out_q     <= 2'b00;
            out_vld_q <= 1'b0;
        end else begin
            if (emit) begin
                out_q     <= {sym_q, last_q & rem_one};
                out_vld_q <= 1'b1;
                rem_q     <= rem_q - CNT_W'(1);
                if (rem_one) begin
                    busy_q <= IDLE;
                end
            end else if (out_load) begin
                out_vld_q <= 1'b0;
            end

            // A zero-count record is consumed without touching the run state.
            if (accept && rec_cnt_nz) begin
                sym_q  <= rec_sym;
                last_q <= rec_last;
                rem_q  <= rec_cnt;
                busy_q <= EXPAND;
            end
        end
    end

`ifdef RLD1_STATS_EN
    logic [15:0] stat_words_q;
    logic [7:0]  stat_zero_q;

    // Saturating activity counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_words_q <= 16'h0000;
            stat_zero_q  <= 8'h00;
        end else begin
            if (emit && (stat_words_q != 16'hFFFF)) begin
                stat_words_q <= stat_words_q + 16'd1;
            end
            if (accept && !rec_cnt_nz && (stat_zero_q != 8'hFF)) begin
                stat_zero_q <= stat_zero_q + 8'd1;
            end
        end
    end

    assign rld1__stat_words = stat_words_q;
    assign rld1__stat_zero  = stat_zero_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_rld1_dec.sv
// Scoreboard bench for rld1_dec: directed scenarios plus randomized records against a queue model.
module tb_rld1_dec;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned REC_W = CNT_W + 2;

    logic             clk;
    logic             reset;
    logic [REC_W-1:0] in_r;
    logic             in_vld;
    logic             in_rdy;
    logic [1:0]       out_s;
    logic             out_vld;
    logic             out_rdy;
`ifdef RLD1_STATS_EN
    logic [15:0]      stat_words;
    logic [7:0]       stat_zero;
`endif

    rld1_dec #(.CNT_W(CNT_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .rld1__input_r      (in_r),
        .rld1__input_r_vld  (in_vld),
        .rld1__input_r_rdy  (in_rdy),
        .rld1__output_s     (out_s),
        .rld1__output_s_vld (out_vld),
        .rld1__output_s_rdy (out_rdy)
`ifdef RLD1_STATS_EN
        ,
        .rld1__stat_words   (stat_words),
        .rld1__stat_zero    (stat_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [1:0] exp_q[$];
    int         words_seen = 0;
    bit         rand_rdy   = 1'b0;
    logic [1:0] prev_s;
    bit         prev_stall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: a record of count n expands to n words, last only on the final one.
    task automatic model_push(input logic s, input int unsigned cnt, input logic l);
        for (int unsigned i = 1; i <= cnt; i++) begin
            exp_q.push_back({s, l && (i == cnt)});
        end
    endtask

    // Monitor: every transferred word is compared against the model queue.
    always @(negedge clk) begin
        if (reset && out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%0h required=none t=%0t", out_s, $time);
            end else begin
                chk("word", 32'(out_s), 32'(exp_q.pop_front()));
            end
            words_seen++;
        end
        if (reset && prev_stall) begin
            chk("hold", 32'({out_vld, out_s}), 32'({1'b1, prev_s}));
        end
        prev_stall = reset && out_vld && !out_rdy;
        prev_s     = out_s;
    end

    // Random downstream back-pressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic s, input logic [CNT_W-1:0] c, input logic l, output int waits);
        bit acc;
        acc   = 1'b0;
        waits = 0;
        in_r  = {s, c, l};
        in_vld = 1'b1;
        for (int n = 0; n < 300 && !acc; n++) begin
            @(negedge clk);
            if (in_rdy) begin
                acc = 1'b1;
                model_push(s, int'(c), l);
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted t=%0t", $time);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 1000 && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_vld) done = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0 t=%0t", exp_q.size(), $time);
        end
    endtask

    int w;
    int base;
    int low_cnt;

    initial begin
        reset   = 1'b0;
        in_vld  = 1'b1;
        in_r    = '0;
        out_rdy = 1'b1;

        // Reset state, ready forced low even with a valid record pending.
        #12;
        chk("reset_out_vld", 32'(out_vld), 32'd0);
        chk("reset_out_s", 32'(out_s), 32'd0);
        chk("reset_in_rdy", 32'(in_rdy), 32'd0);
        in_vld = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single run {1,3,0}: one-cycle latency, three consecutive words.
        send(1'b1, 4'd3, 1'b0, w);
        chk("t1_rdy_on_accept", 32'(w), 32'd0);
        @(negedge clk);
        chk("t1_latency_vld", 32'(out_vld), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_word", 32'({out_vld, out_s}), 32'(3'b110));
        end
        @(negedge clk);
        chk("t1_vld_drop", 32'(out_vld), 32'd0);
        @(posedge clk);
        #1;

        // Max count with last: 14 ready-low cycles, last only on word 15.
        base = words_seen;
        send(1'b0, 4'd15, 1'b1, w);
        low_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_rdy) break;
            low_cnt++;
        end
        chk("t2_rdy_low_cycles", 32'(low_cnt), 32'd14);
        drain();
        chk("t2_word_count", 32'(words_seen - base), 32'd15);

        // Back-to-back: second record taken on the final word of the first.
        send(1'b1, 4'd2, 1'b0, w);
        send(1'b0, 4'd1, 1'b1, w);
        chk("t3_accept_on_final", 32'(w), 32'd1);
        @(negedge clk);
        chk("t3_word2", 32'({out_vld, out_s}), 32'(3'b110));
        @(negedge clk);
        chk("t3_word3", 32'({out_vld, out_s}), 32'(3'b101));
        @(negedge clk);
        chk("t3_vld_drop", 32'(out_vld), 32'd0);
        @(posedge clk);
        #1;

        // Back-pressure mid-run.
        base = words_seen;
        send(1'b1, 4'd4, 1'b0, w);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_stall_in_rdy", 32'(in_rdy), 32'd0);
            chk("t4_stall_word", 32'({out_vld, out_s}), 32'(3'b110));
            @(posedge clk);
            #1;
        end
        out_rdy = 1'b1;
        drain();
        chk("t4_word_count", 32'(words_seen - base), 32'd4);

        // Zero-count record: consumed at once, emits nothing.
        base = words_seen;
        send(1'b1, 4'd0, 1'b1, w);
        chk("t5_rdy_zero", 32'(w), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_no_word", 32'(out_vld), 32'd0);
        end
        chk("t5_word_count", 32'(words_seen - base), 32'd0);
`ifdef RLD1_STATS_EN
        chk("t5_stat_zero", 32'(stat_zero), 32'd1);
        chk("t5_stat_words", 32'(stat_words), 32'(words_seen));
`endif
        @(posedge clk);
        #1;

        // Asynchronous reset during word 2 of a 5-word run.
        send(1'b1, 4'd5, 1'b0, w);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        chk("t6_word2_present", 32'(out_vld), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_async_vld", 32'(out_vld), 32'd0);
        chk("t6_async_rdy", 32'(in_rdy), 32'd0);
        exp_q.delete();
`ifdef RLD1_STATS_EN
        chk("t6_stat_clear", 32'({stat_words, stat_zero}), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_rdy_after", 32'(in_rdy), 32'd1);
        @(posedge clk);
        #1;
        base = words_seen;
        send(1'b0, 4'd1, 1'b0, w);
        @(negedge clk);
        @(negedge clk);
        chk("t6_single_word", 32'({out_vld, out_s}), 32'(3'b100));
        drain();
        chk("t6_word_count", 32'(words_seen - base), 32'd1);

        // Randomized records under random back-pressure.
        rand_rdy = 1'b1;
        for (int r = 0; r < 60; r++) begin
            send(1'($urandom_range(0, 1)), CNT_W'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), w);
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();
        rand_rdy = 1'b0;
        out_rdy  = 1'b1;
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
